reg_list_encoder: RTL and testbench
===================================

Name: reg_list_encoder

Overview:
- Sequential 16-to-4 register-list encoder. It is the inverse of the 4-to-16 register-select decoder.
- It accepts a 16-bit one-hot-per-register mask. Bit 15 is R0 and bit 0 is R15, the same mapping the decoder uses.
- It emits the 4-bit index of each selected register, one per handshake. A register-list instruction (push/pop/load-multiple) uses it to step its register-file port.

Parameters:
ASCEND, 1, 1 = emit lowest register index first (R0 before R15); 0 = emit highest first (R15 before R0)

Ports:
clock  input  1  system clock, rising-edge
clear_n  input  1  asynchronous, active-low reset
start  input  1  begin a new list; sampled only in IDLE
mask_in  input  16  register list; bit 15 = R0 ... bit 0 = R15; captured when start is accepted
next  input  1  consumer accepts the current code; sampled only while code_valid=1
busy  output  1  high from accepted start until the cycle after done
code_valid  output  1  code/onehot hold a valid register index
code  output  4  register index (0 = R0 ... 15 = R15)
onehot  output  16  decoded form of code: code 0 -> 16'h8000 ... code 15 -> 16'h0001; all zero when code_valid=0
count  output  5  number of codes transferred in the current/last list (0..16)
done  output  1  single-cycle pulse marking end of list

Behaviour:
- Reset: clear_n low forces state=IDLE immediately, asynchronously. Outputs: pending=0, busy=0, code_valid=0, code=0, onehot=0, count=0, done=0. Release of clear_n is synchronous to clock.
- All outputs are registered; no input-to-output combinational paths.

States:
- IDLE: busy=0, code_valid=0. start=1 at edge N captures mask_in into the internal pending register, clears count to 0 and sets busy=1.
  - If mask_in != 0: go to EMIT. code is the first set bit in the ASCEND order. code_valid=1 is visible after edge N (1-cycle latency).
  - If mask_in == 0: go to DONE. code_valid never asserts.
- EMIT: code_valid=1, and code/onehot are held stable until a transfer.
  - A transfer is a cycle where code_valid=1 and next=1. At that edge: the pending bit for code clears and count increments.
  - If bits remain: code advances to the next set bit in order and code_valid stays 1, so transfers are back-to-back at one per cycle.
  - If no bits remain: code_valid=0, code=0 and state goes to DONE.
  - next=0 holds everything unchanged.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. count holds its final value until the next accepted start.

Rules and boundary cases:
- start while busy=1 (EMIT or DONE) is ignored. mask_in is not sampled outside IDLE.
- start and next asserted together in IDLE: next is ignored (code_valid=0).
- next outside EMIT has no effect.
- mask 16'hFFFF gives 16 transfers and count=16; count is 5 bits and never wraps.
- Index search is pure priority over the pending register; no per-cycle scan delay.
- clear_n asserted mid-list aborts immediately, discards pending bits and produces no done pulse.

Test Plan:
- ASCEND=1, start with mask_in=16'h8001, next held 1 -> code=0 (onehot 16'h8000) in cycle 1, code=15 (16'h0001) in cycle 2, done in cycle 3, count=2, busy low in cycle 4.
- mask_in=16'h0000 with start -> code_valid never high, done pulses cycle after start, count=0.
- mask_in=16'hFFFF, next toggled 1/0 each cycle -> codes 0..15 in order, each held stable while next=0, count=16, one done pulse.
- ASCEND=0, mask_in=16'h2400 (R2,R5) -> code 5 then code 2; second start with mask 16'h0100 during EMIT ignored.
- clear_n pulsed low while code=3 valid (mask 16'h1F00) -> same-cycle code_valid=0, busy=0, count=0, no done. A following start with mask 16'h0002 gives code 14.
- Backpressure: mask 16'h0410, next low 5 cycles -> code=5 stable 5 cycles, then codes 5, 11 transfer, count=2.

Source files
------------

// File: rtl/reg_list_encoder.sv
// reg_list_encoder: sequential 16-to-4 register-list encoder.
// Takes a register mask (bit 15 = R0 ... bit 0 = R15) and hands out the
// index of each selected register, one per next/code_valid handshake, in
// ascending (ASCEND=1) or descending (ASCEND=0) register order.
module reg_list_encoder #(
    parameter bit ASCEND = 1'b1
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        start,
    input  logic [15:0] mask_in,
    input  logic        next,
    output logic        busy,
    output logic        code_valid,
    output logic [3:0]  code,
    output logic [15:0] onehot,
    output logic [4:0]  count,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pending;
    logic [15:0] remaining;
    logic [3:0]  startIndex;
    logic [3:0]  nextIndex;

    // Priority pick of the first selected register in emission order.
    // The loop runs so that the winning register is assigned last.
    function automatic logic [3:0] firstIndex(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        if (ASCEND) begin
            for (int r = 15; r >= 0; r--) begin
                if (m[15 - r]) begin
                    idx = 4'(r);
                end
            end
        end else begin
            for (int r = 0; r < 16; r++) begin
                if (m[15 - r]) begin
                    idx = 4'(r);
                end
            end
        end
        return idx;
    endfunction

    // Register index to mask bit: R0 is bit 15, R15 is bit 0.
    function automatic logic [15:0] decodeIndex(input logic [3:0] idx);
        return 16'h8000 >> idx;
    endfunction

    // Pending bits left after the current code transfers, and the next/first picks.
    always_comb begin
        remaining  = pending & ~onehot;
        nextIndex  = firstIndex(remaining);
        startIndex = firstIndex(mask_in);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= IDLE;
            pending    <= 16'h0000;
            busy       <= 1'b0;
            code_valid <= 1'b0;
            code       <= 4'd0;
            onehot     <= 16'h0000;
            count      <= 5'd0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pending <= mask_in;
                        count   <= 5'd0;
                        busy    <= 1'b1;
                        if (mask_in != 16'h0000) begin
                            state      <= EMIT;
                            code_valid <= 1'b1;
                            code       <= startIndex;
                            onehot     <= decodeIndex(startIndex);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (next) begin
                        pending <= remaining;
                        count   <= count + 5'd1;
                        if (remaining != 16'h0000) begin
                            code   <= nextIndex;
                            onehot <= decodeIndex(nextIndex);
                        end else begin
                            state      <= DONE;
                            code_valid <= 1'b0;
                            code       <= 4'd0;
                            onehot     <= 16'h0000;
                            done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    pending    <= 16'h0000;
                    busy       <= 1'b0;
                    code_valid <= 1'b0;
                    code       <= 4'd0;
                    onehot     <= 16'h0000;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_list_encoder.sv
// Testbench for reg_list_encoder: one ascending and one descending instance
// share all inputs and are checked every cycle against a list-based model.
module tb_reg_list_encoder;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic [15:0] mask_in;
    logic        next;

    logic        busyA, validA, doneA;
    logic [3:0]  codeA;
    logic [15:0] onehotA;
    logic [4:0]  countA;
    logic        busyD, validD, doneD;
    logic [3:0]  codeD;
    logic [15:0] onehotD;
    logic [4:0]  countD;

    int compared;
    int mismatched;

    // Model: per instance, the ordered list of register indices still to hand out.
    int lst[2][16];
    int len[2];
    int pos[2];
    bit mBusy[2];
    bit mDoneNow[2];

    reg_list_encoder #(.ASCEND(1'b1)) dutAsc (
        .clock(clock), .clear_n(clear_n), .start(start), .mask_in(mask_in), .next(next),
        .busy(busyA), .code_valid(validA), .code(codeA), .onehot(onehotA),
        .count(countA), .done(doneA)
    );

    reg_list_encoder #(.ASCEND(1'b0)) dutDesc (
        .clock(clock), .clear_n(clear_n), .start(start), .mask_in(mask_in), .next(next),
        .busy(busyD), .code_valid(validD), .code(codeD), .onehot(onehotD),
        .count(countD), .done(doneD)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            len[i] = 0; pos[i] = 0; mBusy[i] = 1'b0; mDoneNow[i] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge using the inputs that were held over it.
    task automatic modelStep();
        for (int i = 0; i < 2; i++) begin
            if (!mBusy[i]) begin
                if (start) begin
                    len[i] = 0;
                    for (int k = 0; k < 16; k++) begin
                        int r;
                        r = (i == 0) ? k : 15 - k;
                        if (mask_in[15 - r]) begin
                            lst[i][len[i]] = r;
                            len[i]++;
                        end
                    end
                    pos[i] = 0;
                    mBusy[i] = 1'b1;
                    mDoneNow[i] = (len[i] == 0);
                end
            end else if (mDoneNow[i]) begin
                mDoneNow[i] = 1'b0;
                mBusy[i] = 1'b0;
            end else if (next) begin
                pos[i]++;
                if (pos[i] == len[i]) mDoneNow[i] = 1'b1;
            end
        end
    endtask

    task automatic checkInst(input string n, input int i, input logic b, input logic cv,
                             input logic [3:0] c, input logic [15:0] oh, input logic [4:0] cnt,
                             input logic d);
        logic        eValid;
        logic [3:0]  eCode;
        logic [15:0] eOnehot;
        eValid  = mBusy[i] && !mDoneNow[i] && (pos[i] < len[i]);
        eCode   = eValid ? 4'(lst[i][pos[i]]) : 4'd0;
        eOnehot = eValid ? (16'h0001 << (15 - eCode)) : 16'h0000;
        checkOutput({n, ".busy"}, 32'(b), 32'(mBusy[i]));
        checkOutput({n, ".code_valid"}, 32'(cv), 32'(eValid));
        checkOutput({n, ".code"}, 32'(c), 32'(eCode));
        checkOutput({n, ".onehot"}, 32'(oh), 32'(eOnehot));
        checkOutput({n, ".count"}, 32'(cnt), 32'(pos[i]));
        checkOutput({n, ".done"}, 32'(d), 32'(mDoneNow[i]));
    endtask

    task automatic checkAll();
        checkInst("asc", 0, busyA, validA, codeA, onehotA, countA, doneA);
        checkInst("desc", 1, busyD, validD, codeD, onehotD, countD, doneD);
    endtask

    // Drive one cycle of inputs, let the edge happen, then check both instances.
    task automatic applyStimulus(input logic s, input logic [15:0] m, input logic n);
        start = s; mask_in = m; next = n;
        @(posedge clock);
        #1;
        modelStep();
        checkAll();
    endtask

    // Asynchronous clear in mid-cycle, checked before any clock edge.
    task automatic pulseClear();
        clear_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        clear_n = 1'b0; start = 1'b0; mask_in = 16'h0000; next = 1'b0;
        modelReset();
        #12;
        checkAll();
        @(negedge clock);
        clear_n = 1'b1;

        // Two-entry list with next held high.
        applyStimulus(1'b1, 16'h8001, 1'b1);
        checkOutput("plan1.first", 32'(codeA), 32'd0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("plan1.count", 32'(countA), 32'd2);

        // Empty list goes straight to the done pulse.
        applyStimulus(1'b1, 16'h0000, 1'b1);
        checkOutput("plan2.done", 32'(doneA), 32'd1);
        for (int k = 0; k < 2; k++) applyStimulus(1'b0, 16'h0000, 1'b0);

        // Full list with next toggling every cycle.
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        for (int k = 0; k < 36; k++) applyStimulus(1'b0, 16'h0000, 1'(k % 2 == 0));
        checkOutput("plan3.count", 32'(countA), 32'd16);

        // Start during EMIT is ignored; also start with next in IDLE.
        applyStimulus(1'b1, 16'h2400, 1'b1);
        checkOutput("plan4.first", 32'(codeD), 32'd5);
        applyStimulus(1'b1, 16'h0100, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h0000, 1'b1);

        // Clear while a code is valid, then a fresh list.
        applyStimulus(1'b1, 16'h1F00, 1'b0);
        checkOutput("plan5.code3", 32'(codeA), 32'd3);
        pulseClear();
        applyStimulus(1'b1, 16'h0002, 1'b0);
        checkOutput("plan5.code14", 32'(codeA), 32'd14);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h0000, 1'b1);

        // Backpressure: hold next low, then drain.
        applyStimulus(1'b1, 16'h0410, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 16'h0000, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("plan6.count", 32'(countA), 32'd2);

        // Randomized lists with random backpressure, stray starts and clears.
        for (int t = 0; t < 25; t++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (t % 7 == 3) m = 16'h0000;
            if (t % 7 == 5) m = 16'hFFFF;
            applyStimulus(1'b1, m, 1'($urandom_range(0, 1)));
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 63) == 0) pulseClear();
                applyStimulus(1'($urandom_range(0, 7) == 0), 16'($urandom), 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
